// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register master: command layout, PWM
// peripheral register map, PWM function codes and the frame FSM states.
package spi_pkg;

   localparam int CMD_RW_BIT   = 7;
   localparam int CMD_BIT6     = 6;
   localparam int CMD_ADDR_MSB = 5;

   localparam int FRAME_BITS = 16;
   localparam int BYTE_BITS  = 8;

   localparam logic [5:0] REG_PERIOD        = 6'h00;
   localparam logic [5:0] REG_COUNTER_EN    = 6'h02;
   localparam logic [5:0] REG_COMPARE1      = 6'h03;
   localparam logic [5:0] REG_COMPARE2      = 6'h05;
   localparam logic [5:0] REG_COUNTER_RESET = 6'h07;
   localparam logic [5:0] REG_COUNTER_VAL   = 6'h08;
   localparam logic [5:0] REG_PRESCALE      = 6'h0A;
   localparam logic [5:0] REG_UPNOTDOWN     = 6'h0B;
   localparam logic [5:0] REG_PWM_EN        = 6'h0C;
   localparam logic [5:0] REG_FUNCTIONS     = 6'h0D;

   typedef enum logic [1:0] {
      FUNC_ALIGN_LEFT             = 2'b00,
      FUNC_ALIGN_RIGHT            = 2'b01,
      FUNC_RANGE_BETWEEN_COMPARES = 2'b10
   } func_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_e;

   // Assemble the two-byte frame: command byte (rw, bit6, address) then data.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic       wr,
      input logic       bit6,
      input logic [5:0] addr,
      input logic [7:0] data
   );
      logic [BYTE_BITS-1:0] cmd;
      cmd                       = '0;
      cmd[CMD_RW_BIT]           = wr;
      cmd[CMD_BIT6]             = bit6;
      cmd[CMD_ADDR_MSB -: 6]    = addr;
      return {cmd, data};
   endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period tick generator for the SPI clock. Reloads on frame start and
// on every terminal count, so ticks land exactly every HALF_CYCLES clocks.
module spi_sclk_div #(
   parameter int HALF_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic tick
);

   localparam logic [7:0] RELOAD = 8'(HALF_CYCLES - 1);

   logic [7:0] count;

   // Down-counter that restarts at frame start and wraps at zero while running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 8'd0;
      end else if (start) begin
         count <= RELOAD;
      end else if (run) begin
         if (count == 8'd0) begin
            count <= RELOAD;
         end else begin
            count <= count - 8'd1;
         end
      end
   end

   assign tick = run && (count == 8'd0);

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for the PWM peripheral register interface. Each
// accepted request becomes one 16-bit frame (command byte, data byte); the
// second byte seen on miso is returned on a one-cycle response strobe.
module spi_reg_master
   import spi_pkg::*;
#(
   parameter int SCLK_HALF_CYCLES = 2,
   parameter int CS_GAP_CYCLES    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic       req_bit6,
   input  logic [5:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso
);

   localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP_CYCLES - 1);

   state_e      state_q, state_d;
   logic [14:0] tx_q, tx_d;
   logic [7:0]  rx_q, rx_d;
   logic [3:0]  bit_q, bit_d;
   logic        phase_q, phase_d;
   logic [7:0]  gap_q, gap_d;
   logic        sclk_q, sclk_d;
   logic        cs_n_q, cs_n_d;
   logic        mosi_q, mosi_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;

   logic [15:0] frame;
   logic        accept;
   logic        div_run;
   logic        tick;

   assign frame   = build_frame(req_write, req_bit6, req_addr, req_wdata);
   assign accept  = req_valid && (state_q == ST_IDLE);
   assign div_run = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

   spi_sclk_div #(
      .HALF_CYCLES(SCLK_HALF_CYCLES)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .run   (div_run),
      .tick  (tick)
   );

   // Next-state and next-output logic; every register holds unless a tick or acceptance moves it.
   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_d       = bit_q;
      phase_d     = phase_q;
      gap_d       = gap_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_SETUP;
               tx_d    = frame[14:0];
               mosi_d  = frame[15];
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               bit_d   = 4'd15;
               phase_d = 1'b0;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (!phase_q) begin
                  sclk_d  = 1'b1;
                  phase_d = 1'b1;
               end else begin
                  sclk_d  = 1'b0;
                  phase_d = 1'b0;
                  if (bit_q <= 4'd7) begin
                     rx_d = {rx_q[6:0], miso};
                  end
                  if (bit_q == 4'd0) begin
                     state_d = ST_HOLD;
                     mosi_d  = 1'b0;
                  end else begin
                     bit_d  = bit_q - 4'd1;
                     mosi_d = tx_q[14];
                     tx_d   = {tx_q[13:0], 1'b0};
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_d     = ST_GAP;
               cs_n_d      = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rx_q;
               gap_d       = GAP_RELOAD;
            end
         end
         ST_GAP: begin
            if (gap_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   // State and pin registers; pins come straight from flops so they never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tx_q        <= 15'd0;
         rx_q        <= 8'd0;
         bit_q       <= 4'd0;
         phase_q     <= 1'b0;
         gap_q       <= 8'd0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_q       <= bit_d;
         phase_q     <= phase_d;
         gap_q       <= gap_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign sclk      = sclk_q;
   assign cs_n      = cs_n_q;
   assign mosi      = mosi_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Testbench for spi_reg_master: a default-timing instance and a fast-sclk
// instance share one bus monitor, behavioural slave and scoreboard.
module tb_spi_reg_master;
   import spi_pkg::*;

   localparam int H_MAIN = 2;
   localparam int H_FAST = 1;
   localparam int G      = 4;

   typedef struct {
      logic [15:0] word;
      logic [7:0]  rd;
   } exp_t;

   typedef struct {
      logic [7:0]  rd;
      logic [15:0] word;
      int          low;
      int          rises;
      logic        cs;
      logic        prev;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sel = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic       req_bit6 = 1'b0;
   logic [5:0] req_addr = 6'd0;
   logic [7:0] req_wdata = 8'd0;
   logic       miso = 1'b0;

   logic       req_ready_s, rsp_valid_s, busy_s, sclk_s, cs_n_s, mosi_s;
   logic [7:0] rsp_rdata_s;
   logic       req_ready_f, rsp_valid_f, busy_f, sclk_f, cs_n_f, mosi_f;
   logic [7:0] rsp_rdata_f;

   logic       m_ready, m_rsp_valid, m_busy, m_sclk, m_cs_n, m_mosi;
   logic [7:0] m_rsp_rdata;

   exp_t exp_q[$];
   obs_t obs_q[$];
   logic [7:0] slave_q[$];

   int checks = 0;
   int errors = 0;

   // Monitor/slave state
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        prev_rsp = 1'b0;
   int          low_cnt = 0;
   int          rise_cnt = 0;
   int          high_cnt = 0;
   int          last_low = 0;
   int          last_rises = 0;
   int          last_gap = 0;
   logic [15:0] cap = 16'd0;
   logic [15:0] last_word = 16'd0;
   logic [15:0] slave_word = 16'd0;

   always #5 clk = ~clk;

   spi_reg_master #(
      .SCLK_HALF_CYCLES(H_MAIN),
      .CS_GAP_CYCLES(G)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && !sel), .req_ready(req_ready_s),
      .req_write(req_write), .req_bit6(req_bit6), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_s), .rsp_rdata(rsp_rdata_s), .busy(busy_s),
      .sclk(sclk_s), .cs_n(cs_n_s), .mosi(mosi_s), .miso(miso)
   );

   spi_reg_master #(
      .SCLK_HALF_CYCLES(H_FAST),
      .CS_GAP_CYCLES(G)
   ) dut_fast (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && sel), .req_ready(req_ready_f),
      .req_write(req_write), .req_bit6(req_bit6), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_f), .rsp_rdata(rsp_rdata_f), .busy(busy_f),
      .sclk(sclk_f), .cs_n(cs_n_f), .mosi(mosi_f), .miso(miso)
   );

   assign m_ready     = sel ? req_ready_f : req_ready_s;
   assign m_rsp_valid = sel ? rsp_valid_f : rsp_valid_s;
   assign m_rsp_rdata = sel ? rsp_rdata_f : rsp_rdata_s;
   assign m_busy      = sel ? busy_f : busy_s;
   assign m_sclk      = sel ? sclk_f : sclk_s;
   assign m_cs_n      = sel ? cs_n_f : cs_n_s;
   assign m_mosi      = sel ? mosi_f : mosi_s;

   // Bus monitor and behavioural slave, sampled mid-cycle on the falling clk edge
   always @(negedge clk) begin
      if (prev_cs && !m_cs_n) begin
         low_cnt    = 0;
         rise_cnt   = 0;
         cap        = 16'd0;
         last_gap   = high_cnt;
         slave_word = 16'd0;
         if (slave_q.size() > 0) begin
            slave_word[7:0]  = slave_q.pop_front();
            slave_word[15:8] = ~slave_word[7:0];
         end
      end
      if (!m_cs_n) begin
         low_cnt = low_cnt + 1;
         if (m_sclk && !prev_sclk) begin
            rise_cnt = rise_cnt + 1;
            cap      = {cap[14:0], m_mosi};
         end
      end else begin
         if (!prev_cs) begin
            last_low   = low_cnt;
            last_rises = rise_cnt;
            last_word  = cap;
            high_cnt   = 1;
         end else begin
            high_cnt = high_cnt + 1;
         end
      end
      if (!m_cs_n && rise_cnt >= 1 && rise_cnt <= 16) miso = slave_word[16 - rise_cnt];
      else miso = 1'b0;
      if (m_rsp_valid) obs_q.push_back('{m_rsp_rdata, last_word, last_low, last_rises, m_cs_n, prev_rsp});
      prev_cs   = m_cs_n;
      prev_sclk = m_sclk;
      prev_rsp  = m_rsp_valid;
   end

   task automatic send_req(input logic w, input logic b6, input logic [5:0] a, input logic [7:0] d,
                           input logic [7:0] slave_byte, input bit keep,
                           output bit ok, output time t_ready, output time t_acc);
      exp_t e;
      @(negedge clk);
      req_write = w;
      req_bit6  = b6;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      ok = 1'b0;
      t_ready = 0;
      t_acc = 0;
      for (int i = 0; i < 400; i++) begin
         if (m_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         t_ready = $time;
         @(posedge clk);
         t_acc  = $time;
         e.word = {w, b6, a, d};
         e.rd   = slave_byte;
         exp_q.push_back(e);
         slave_q.push_back(slave_byte);
         #1;
      end
      if (!keep || !ok) req_valid = 1'b0;
   endtask

   task automatic wait_obs(output bit got);
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (obs_q.size() > 0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if ({cs_n_s, sclk_s, mosi_s, rsp_valid_s, busy_s, req_ready_s} !== 6'b100001) begin
         errors++;
         $display("[TB] FAIL reset_pins: got %b expected 100001", {cs_n_s, sclk_s, mosi_s, rsp_valid_s, busy_s, req_ready_s});
      end
      checks++;
      if (rsp_rdata_s !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_rdata: got %h expected 00", rsp_rdata_s);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write();
      bit ok, got;
      time tr, ta;
      obs_t o;
      exp_t e;
      sel = 1'b0;
      send_req(1'b1, 1'b1, REG_PERIOD, 8'h07, 8'h96, 1'b0, ok, tr, ta);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL write_accept: got not-ready expected ready"); end
      wait_obs(got);
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL write_rsp: got no rsp_valid expected one");
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.word !== e.word) begin errors++; $display("[TB] FAIL write_mosi: got %h expected %h", o.word, e.word); end
         checks++;
         if (o.rd !== e.rd) begin errors++; $display("[TB] FAIL write_rdata: got %h expected %h", o.rd, e.rd); end
         checks++;
         if (o.low != 34 * H_MAIN) begin errors++; $display("[TB] FAIL write_cs_low: got %0d expected %0d", o.low, 34 * H_MAIN); end
         checks++;
         if (o.rises != 16) begin errors++; $display("[TB] FAIL write_rises: got %0d expected 16", o.rises); end
         checks++;
         if ({o.cs, o.prev} !== 2'b10) begin errors++; $display("[TB] FAIL write_rsp_timing: got %b expected 10", {o.cs, o.prev}); end
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL write_rsp_width: got %0d extra strobes expected 0", obs_q.size()); end
   endtask

   task automatic test_read(input logic [7:0] slave_byte);
      bit ok, got;
      time tr, ta;
      obs_t o;
      exp_t e;
      sel = 1'b0;
      send_req(1'b0, 1'b1, REG_COUNTER_VAL, 8'h00, slave_byte, 1'b0, ok, tr, ta);
      wait_obs(got);
      checks++;
      if (!ok || !got) begin
         errors++;
         $display("[TB] FAIL read_rsp: got ok=%0d rsp=%0d expected 1 1", ok, got);
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.word[15:8] !== 8'h48 || o.word !== e.word) begin
            errors++; $display("[TB] FAIL read_mosi: got %h expected %h", o.word, e.word);
         end
         checks++;
         if (o.rd !== e.rd) begin errors++; $display("[TB] FAIL read_rdata: got %h expected %h", o.rd, e.rd); end
         checks++;
         if (o.low != 34 * H_MAIN || o.rises != 16) begin
            errors++; $display("[TB] FAIL read_framing: got low=%0d rises=%0d expected %0d 16", o.low, o.rises, 34 * H_MAIN);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2, got;
      time tr1, ta1, tr2, ta2;
      obs_t o;
      exp_t e;
      sel = 1'b0;
      send_req(1'b1, 1'b1, REG_PRESCALE, 8'h33, 8'h81, 1'b1, ok1, tr1, ta1);
      send_req(1'b0, 1'b1, REG_UPNOTDOWN, 8'h00, 8'hC3, 1'b0, ok2, tr2, ta2);
      checks++;
      if (!ok1 || !ok2) begin errors++; $display("[TB] FAIL b2b_accept: got %0d %0d expected 1 1", ok1, ok2); end
      checks++;
      if (tr2 - ta1 != (34 * H_MAIN + G) * 10 + 5) begin
         errors++; $display("[TB] FAIL b2b_ready_time: got %0t expected %0d", tr2 - ta1, (34 * H_MAIN + G) * 10 + 5);
      end
      checks++;
      if (ta2 - ta1 != (1 + 34 * H_MAIN + G) * 10) begin
         errors++; $display("[TB] FAIL b2b_accept_spacing: got %0t expected %0d", ta2 - ta1, (1 + 34 * H_MAIN + G) * 10);
      end
      for (int f = 0; f < 2; f++) begin
         wait_obs(got);
         checks++;
         if (!got) begin
            errors++; $display("[TB] FAIL b2b_rsp: got no rsp for frame %0d expected one", f);
         end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if ({o.word, o.rd} !== {e.word, e.rd}) begin
               errors++; $display("[TB] FAIL b2b_frame: got %h/%h expected %h/%h", o.word, o.rd, e.word, e.rd);
            end
         end
      end
      checks++;
      if (last_gap < G) begin errors++; $display("[TB] FAIL b2b_cs_gap: got %0d expected >= %0d", last_gap, G); end
      repeat (G + 2) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      bit ok, got;
      time tr, ta;
      obs_t o;
      exp_t e;
      sel = 1'b0;
      send_req(1'b1, 1'b1, REG_COUNTER_RESET, 8'h01, 8'h00, 1'b0, ok, tr, ta);
      #((14 * H_MAIN) * 10 + 2);
      checks++;
      if ({cs_n_s, sclk_s, mosi_s} !== 3'b011) begin
         errors++; $display("[TB] FAIL bit9_pins: got %b expected 011", {cs_n_s, sclk_s, mosi_s});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({cs_n_s, sclk_s, mosi_s, busy_s} !== 4'b1000) begin
         errors++; $display("[TB] FAIL async_reset_pins: got %b expected 1000", {cs_n_s, sclk_s, mosi_s, busy_s});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      #1;
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL reset_no_rsp: got %0d strobes expected 0", obs_q.size()); end
      exp_q.delete();
      obs_q.delete();
      send_req(1'b1, 1'b1, REG_PWM_EN, 8'h01, 8'h5C, 1'b0, ok, tr, ta);
      wait_obs(got);
      checks++;
      if (!got) begin
         errors++; $display("[TB] FAIL post_reset_rsp: got no rsp expected one");
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.word !== 16'hCC01 || o.word !== e.word) begin
            errors++; $display("[TB] FAIL post_reset_mosi: got %h expected %h", o.word, e.word);
         end
         checks++;
         if (o.low != 34 * H_MAIN || o.rises != 16) begin
            errors++; $display("[TB] FAIL post_reset_framing: got low=%0d rises=%0d expected %0d 16", o.low, o.rises, 34 * H_MAIN);
         end
      end
      repeat (G + 2) @(negedge clk);
   endtask

   task automatic test_fast_sclk();
      bit ok, got;
      time tr, ta;
      obs_t o;
      exp_t e;
      sel = 1'b1;
      send_req(1'b0, 1'b1, REG_PRESCALE, 8'h00, 8'h3C, 1'b0, ok, tr, ta);
      wait_obs(got);
      checks++;
      if (!ok || !got) begin
         errors++; $display("[TB] FAIL fast_rsp: got ok=%0d rsp=%0d expected 1 1", ok, got);
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if ({o.word, o.rd} !== {e.word, e.rd}) begin
            errors++; $display("[TB] FAIL fast_frame: got %h/%h expected %h/%h", o.word, o.rd, e.word, e.rd);
         end
         checks++;
         if (o.low != 34 * H_FAST || o.rises != 16) begin
            errors++; $display("[TB] FAIL fast_framing: got low=%0d rises=%0d expected %0d 16", o.low, o.rises, 34 * H_FAST);
         end
      end
      repeat (G + 2) @(negedge clk);
      sel = 1'b0;
   endtask

   // Test sequence
   initial begin
      #2;
      test_reset();
      test_write();
      test_read(8'hA5);
      test_read(8'h5A);
      test_back_to_back();
      test_reset_mid_frame();
      test_fast_sclk();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
